mult_div_unit: RTL and testbench

//  Parametrised multicycle multiply/divide unit for the multicycle MIPS datapath (MULT, MULTU, DIV, DIVU).

---
 rtl/mult_div_pkg.sv | 27 ++
 rtl/mult_div_unit_cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types for the multicycle multiply/divide unit: op encoding, FSM states,
// and small op-decoding helpers.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   function automatic logic is_div(input op_t op);
      return op[1];
   endfunction

   function automatic logic is_signed_op(input op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result fixup.
module cond_negate #(
   parameter int N = 32
) (
   input  logic         neg,
   input  logic [N-1:0] in,
   output logic [N-1:0] out
);

   assign out = neg ? -in : in;

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 shift-add multiply / restoring divide, one bit per cycle, results in HI/LO.
// Optional feature: define MULT_DIV_ABORT_EN to add the abort input.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MULT_DIV_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int AW    = 2 * WIDTH + 1;

   state_t             state, state_next;
   op_t                op_in, op_q;
   logic               neg_q, rem_neg_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [AW-1:0]      acc;
   logic [CNT_W-1:0]   cnt;

   logic               sign_a, sign_b, accept, dz_start, abort_hit;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, trial;
   logic [AW-1:0]      mul_next, shifted, div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign op_in    = op_t'(op);
   assign sign_a   = is_signed_op(op_in) & a[WIDTH-1];
   assign sign_b   = is_signed_op(op_in) & b[WIDTH-1];
   assign accept   = start && (state == S_IDLE || state == S_DONE);
   assign dz_start = accept && is_div(op_in) && (b == '0);
   assign busy     = (state == S_RUN) || (state == S_FIX);
   assign done     = (state == S_DONE);

`ifdef MULT_DIV_ABORT_EN
   assign abort_hit = abort && busy;
`else
   assign abort_hit = 1'b0;
`endif

   cond_negate #(.N(WIDTH)) u_mag_a (.neg(sign_a), .in(a), .out(mag_a));
   cond_negate #(.N(WIDTH)) u_mag_b (.neg(sign_b), .in(b), .out(mag_b));

   // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
   assign add_sum  = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, mag_b_q} : '0);
   assign mul_next = {1'b0, add_sum, acc[WIDTH-1:1]};

   // Divide: {remainder, dividend/quotient}; the quotient bit enters at bit 0.
   assign shifted  = {acc[AW-2:0], 1'b0};
   assign trial    = shifted[AW-1:WIDTH] - {1'b0, mag_b_q};
   assign div_next = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};

   cond_negate #(.N(2*WIDTH)) u_fix_prod (.neg(neg_q),     .in(acc[2*WIDTH-1:0]),     .out(prod_fix));
   cond_negate #(.N(WIDTH))   u_fix_quot (.neg(neg_q),     .in(acc[WIDTH-1:0]),       .out(quot_fix));
   cond_negate #(.N(WIDTH))   u_fix_rem  (.neg(rem_neg_q), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_next = dz_start ? S_DONE : S_RUN;
            else        state_next = S_IDLE;
         end
         S_RUN:   if (cnt == CNT_W'(1)) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
      if (abort_hit) state_next = S_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_q      <= OP_MULT;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         mag_b_q   <= '0;
         acc       <= '0;
         cnt       <= '0;
         div_zero  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else if (accept) begin
         op_q      <= op_in;
         neg_q     <= sign_a ^ sign_b;
         rem_neg_q <= sign_a;
         mag_b_q   <= mag_b;
         acc       <= {{(WIDTH+1){1'b0}}, mag_a};
         cnt       <= CNT_W'(WIDTH);
         div_zero  <= dz_start;
         if (dz_start) begin
            hi <= a;
            lo <= '1;
         end
      end else if (state == S_RUN && !abort_hit) begin
         acc <= is_div(op_q) ? div_next : mul_next;
         cnt <= cnt - CNT_W'(1);
      end else if (state == S_FIX && !abort_hit) begin
         if (is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quot_fix;
         end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, randomized ops against an
// arithmetic reference model, back-to-back, start-while-busy, reset mid-run, and WIDTH=8.
module tb_mult_div_unit;

   localparam int W  = 32;
   localparam int W8 = 8;

   logic           clock, reset;
   logic           start, abort;
   logic [1:0]     op;
   logic [W-1:0]   a, b, hi, lo;
   logic           busy, done, div_zero;
   logic           start8;
   logic [1:0]     op8;
   logic [W8-1:0]  a8, b8, hi8, lo8;
   logic           busy8, done8, div_zero8;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] last_hi, last_lo;
   logic [2*W:0] exp_q[$];

   mult_div_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MULT_DIV_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mult_div_unit #(.WIDTH(W8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
`ifdef MULT_DIV_ABORT_EN
      .abort(1'b0),
`endif
      .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: plain integer arithmetic at width w (w <= 32).
   function automatic void model(input int w, input logic [1:0] o,
                                 input longint unsigned x, input longint unsigned y,
                                 output longint unsigned m_hi, output longint unsigned m_lo,
                                 output logic m_dz);
      longint unsigned mask, pu;
      longint sx, sy, p;
      mask = (64'd1 << w) - 64'd1;
      sx = $signed(x << (64 - w)); sx = sx >>> (64 - w);
      sy = $signed(y << (64 - w)); sy = sy >>> (64 - w);
      m_dz = 1'b0;
      m_hi = 0;
      m_lo = 0;
      case (o)
         2'd0: begin
            p = sx * sy;
            m_hi = ($unsigned(p) >> w) & mask;
            m_lo = $unsigned(p) & mask;
         end
         2'd1: begin
            pu = x * y;
            m_hi = (pu >> w) & mask;
            m_lo = pu & mask;
         end
         default: begin
            if (y == 0) begin
               m_hi = x; m_lo = mask; m_dz = 1'b1;
            end else if (o == 2'd2) begin
               m_lo = $unsigned(sx / sy) & mask;
               m_hi = $unsigned(sx % sy) & mask;
            end else begin
               m_lo = (x / y) & mask;
               m_hi = (x % y) & mask;
            end
         end
      endcase
   endfunction

   // Caller is at a negedge; returns at the negedge of the done cycle (or on timeout).
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int busy_n);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1; busy_n = 0;
      for (int n = 1; n <= W + 10; n++) begin
         @(negedge clock);
         if (busy) busy_n++;
         if (done) begin lat = n; break; end
      end
   endtask

   task automatic run_op8(input logic [1:0] o, input logic [W8-1:0] x, input logic [W8-1:0] y,
                          output int lat, output int busy_n);
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clock); #1;
      start8 = 1'b0;
      lat = -1; busy_n = 0;
      for (int n = 1; n <= W8 + 10; n++) begin
         @(negedge clock);
         if (busy8) busy_n++;
         if (done8) begin lat = n; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, done, div_zero} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got busy/done/dz=%b expected 000", {busy, done, div_zero});
      end
      checks++;
      if ({hi, lo} !== {2*W{1'b0}}) begin
         errors++; $display("FAIL reset_hilo got hi=%h lo=%h expected 0/0", hi, lo);
      end
      checks++;
      if ({busy8, done8, div_zero8, hi8, lo8} !== '0) begin
         errors++; $display("FAIL reset_w8 got hi=%h lo=%h flags=%b expected zeros", hi8, lo8, {busy8, done8, div_zero8});
      end
      last_hi = '0; last_lo = '0;
   endtask

   task automatic test_directed();
      logic [1:0]   t_op [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
      logic [W-1:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'h80000000};
      logic [W-1:0] t_b  [5] = '{32'hFFFFFFFF, 32'h6, 32'h2, 32'h0, 32'hFFFFFFFF};
      logic [W-1:0] t_hi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h0};
      logic [W-1:0] t_lo [5] = '{32'h00000001, 32'hFFFFFFD6, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
      logic         t_dz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int lat, busy_n;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         run_op(t_op[i], t_a[i], t_b[i], lat, busy_n);
         checks++;
         if (lat != (t_dz[i] ? 1 : W + 2)) begin
            errors++; $display("FAIL directed_latency[%0d] got %0d expected %0d", i, lat, t_dz[i] ? 1 : W + 2);
         end
         checks++;
         if (busy_n != (t_dz[i] ? 0 : W + 1)) begin
            errors++; $display("FAIL directed_busy[%0d] got %0d cycles expected %0d", i, busy_n, t_dz[i] ? 0 : W + 1);
         end
         checks++;
         if ({div_zero, hi, lo} !== {t_dz[i], t_hi[i], t_lo[i]}) begin
            errors++; $display("FAIL directed_result[%0d] got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                               i, div_zero, hi, lo, t_dz[i], t_hi[i], t_lo[i]);
         end
         last_hi = t_hi[i]; last_lo = t_lo[i];
      end
   endtask

   task automatic test_random();
      longint unsigned m_hi, m_lo;
      logic m_dz;
      logic [1:0] o;
      logic [W-1:0] x, y;
      logic [2*W:0] exp;
      int lat, busy_n, pick;
      @(negedge clock);
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         pick = $urandom_range(0, 9);
         if (pick == 0) y = '0;
         if (pick == 1) begin y = '1; x = 32'h80000000; end
         if (pick == 2) y = W'($urandom_range(1, 15));
         model(W, o, longint'(x), longint'(y), m_hi, m_lo, m_dz);
         exp_q.push_back({m_dz, m_hi[W-1:0], m_lo[W-1:0]});
         run_op(o, x, y, lat, busy_n);
         exp = exp_q.pop_front();
         checks++;
         if (lat != (exp[2*W] ? 1 : W + 2)) begin
            errors++; $display("FAIL random_latency[%0d] op=%0d got %0d expected %0d", i, o, lat, exp[2*W] ? 1 : W + 2);
         end
         checks++;
         if ({div_zero, hi, lo} !== exp) begin
            errors++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                               i, o, x, y, div_zero, hi, lo, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
         end
         last_hi = exp[2*W-1:W]; last_lo = exp[W-1:0];
         if ($urandom_range(0, 1) == 1) @(negedge clock);
      end
   endtask

   task automatic test_start_while_busy();
      longint unsigned m_hi, m_lo;
      logic m_dz;
      logic [W-1:0] x, y, got_hi, got_lo;
      int dones, hold_bad;
      x = $urandom; y = $urandom;
      model(W, 2'd0, longint'(x), longint'(y), m_hi, m_lo, m_dz);
      @(negedge clock);
      start = 1'b1; op = 2'd0; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0;
      dones = 0; hold_bad = 0; got_hi = '0; got_lo = '0;
      for (int n = 1; n <= 2 * W + 10; n++) begin
         @(negedge clock);
         if (busy && (hi !== last_hi || lo !== last_lo)) hold_bad++;
         if (done) begin
            dones++; got_hi = hi; got_lo = lo;
         end
         if (n == 3) begin start = 1'b1; op = 2'd3; a = 32'h5; b = 32'h0; end
         if (n == 5) start = 1'b0;
      end
      checks++;
      if (dones != 1) begin
         errors++; $display("FAIL busy_start_dones got %0d expected 1", dones);
      end
      checks++;
      if (hold_bad != 0) begin
         errors++; $display("FAIL busy_hold got %0d changed cycles expected 0", hold_bad);
      end
      checks++;
      if ({got_hi, got_lo} !== {m_hi[W-1:0], m_lo[W-1:0]}) begin
         errors++; $display("FAIL busy_start_result got hi=%h lo=%h expected hi=%h lo=%h", got_hi, got_lo, m_hi[W-1:0], m_lo[W-1:0]);
      end
      last_hi = m_hi[W-1:0]; last_lo = m_lo[W-1:0];
   endtask

   task automatic test_back_to_back();
      longint unsigned h1, l1, h2, l2;
      logic d1, d2;
      logic [W-1:0] x1, y1, x2, y2;
      int lat, busy_n;
      x1 = $urandom; y1 = $urandom;
      x2 = $urandom; y2 = W'($urandom_range(1, 1000));
      model(W, 2'd1, longint'(x1), longint'(y1), h1, l1, d1);
      model(W, 2'd2, longint'(x2), longint'(y2), h2, l2, d2);
      @(negedge clock);
      run_op(2'd1, x1, y1, lat, busy_n);
      checks++;
      if ({hi, lo} !== {h1[W-1:0], l1[W-1:0]}) begin
         errors++; $display("FAIL b2b_first got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, h1[W-1:0], l1[W-1:0]);
      end
      run_op(2'd2, x2, y2, lat, busy_n);
      checks++;
      if (lat != W + 2) begin
         errors++; $display("FAIL b2b_latency got %0d expected %0d", lat, W + 2);
      end
      checks++;
      if ({div_zero, hi, lo} !== {1'b0, h2[W-1:0], l2[W-1:0]}) begin
         errors++; $display("FAIL b2b_second got dz=%b hi=%h lo=%h expected dz=0 hi=%h lo=%h", div_zero, hi, lo, h2[W-1:0], l2[W-1:0]);
      end
      last_hi = h2[W-1:0]; last_lo = l2[W-1:0];
   endtask

   task automatic test_reset_mid_run();
      int dones;
      @(negedge clock);
      start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, done, div_zero, hi, lo} !== '0) begin
         errors++; $display("FAIL reset_mid_run got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0", busy, done, div_zero, hi, lo);
      end
      dones = 0;
      for (int n = 0; n < W + 6; n++) begin
         @(negedge clock);
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL reset_mid_run_done got %0d pulses expected 0", dones);
      end
      last_hi = '0; last_lo = '0;
   endtask

`ifdef MULT_DIV_ABORT_EN
   task automatic test_abort();
      int lat, busy_n, dones;
      @(negedge clock);
      run_op(2'd0, 32'hFFFFFFF9, 32'h6, lat, busy_n);
      checks++;
      if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFD6}) begin
         errors++; $display("FAIL abort_prior got hi=%h lo=%h expected FFFFFFFF/FFFFFFD6", hi, lo);
      end
      @(negedge clock);
      start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(negedge clock);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, done, div_zero, hi, lo} !== {3'b000, 32'hFFFFFFFF, 32'hFFFFFFD6}) begin
         errors++; $display("FAIL abort_state got busy=%b done=%b dz=%b hi=%h lo=%h expected 000 FFFFFFFF FFFFFFD6", busy, done, div_zero, hi, lo);
      end
      dones = 0;
      for (int n = 0; n < W + 6; n++) begin
         @(negedge clock);
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL abort_done got %0d pulses expected 0", dones);
      end
   endtask
`endif

   task automatic test_width8();
      logic [1:0]    t_op [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
      logic [W8-1:0] t_a  [5] = '{8'hFF, 8'hF9, 8'hF9, 8'h07, 8'h80};
      logic [W8-1:0] t_b  [5] = '{8'hFF, 8'h06, 8'h02, 8'h00, 8'hFF};
      logic [W8-1:0] t_hi [5] = '{8'hFE, 8'hFF, 8'hFF, 8'h07, 8'h00};
      logic [W8-1:0] t_lo [5] = '{8'h01, 8'hD6, 8'hFD, 8'hFF, 8'h80};
      logic          t_dz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      longint unsigned m_hi, m_lo;
      logic m_dz;
      logic [1:0] o;
      logic [W8-1:0] x, y;
      int lat, busy_n;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         run_op8(t_op[i], t_a[i], t_b[i], lat, busy_n);
         checks++;
         if (lat != (t_dz[i] ? 1 : W8 + 2)) begin
            errors++; $display("FAIL w8_latency[%0d] got %0d expected %0d", i, lat, t_dz[i] ? 1 : W8 + 2);
         end
         checks++;
         if ({div_zero8, hi8, lo8} !== {t_dz[i], t_hi[i], t_lo[i]}) begin
            errors++; $display("FAIL w8_result[%0d] got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                               i, div_zero8, hi8, lo8, t_dz[i], t_hi[i], t_lo[i]);
         end
      end
      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         x = W8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 8'h00 : W8'($urandom);
         model(W8, o, longint'(x), longint'(y), m_hi, m_lo, m_dz);
         @(negedge clock);
         run_op8(o, x, y, lat, busy_n);
         checks++;
         if ({lat, div_zero8, hi8, lo8} !== {(m_dz ? 32'd1 : 32'(W8 + 2)), m_dz, m_hi[W8-1:0], m_lo[W8-1:0]}) begin
            errors++; $display("FAIL w8_random[%0d] op=%0d a=%h b=%h got lat=%0d dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                               i, o, x, y, lat, div_zero8, hi8, lo8, m_dz, m_hi[W8-1:0], m_lo[W8-1:0]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
`ifdef MULT_DIV_ABORT_EN
      test_abort();
`endif
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
